// File: rtl/mem_access_ctrl_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
//
// Handshaked data-memory bus between the memory-stage controller and the
// multi-cycle data memory. One request is outstanding at a time; the memory
// finishes it with a one-cycle mem_ack strobe.
//
// Signals:
//   mem_req    request valid, held until ack or abort (controller -> memory)
//   mem_we     1 = write, 0 = read                    (controller -> memory)
//   mem_addr   word address, AW bits                  (controller -> memory)
//   mem_wdata  store data                             (controller -> memory)
//   mem_rdata  load data, valid while mem_ack is high (memory -> controller)
//   mem_ack    one-cycle completion strobe            (memory -> controller)
//
// Modports:
//   master  the memory-stage controller
//   slave   the data memory
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if #(
   parameter int AW = 8
) ();

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ack
   );

endinterface

// File: rtl/mem_access_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Memory-stage sequencer for the 32-bit pipeline. Takes the load/store held
// in the EX/MEM register, issues exactly one handshaked transaction to the
// multi-cycle data memory, stalls the upstream pipeline with freeze until the
// access has finished, and presents the last load result to MEM/WB.
//
// Parameters:
//   ADDR_BASE  byte address that maps to data-memory word 0
//   AW         word-address width driven to the memory
//   TIMEOUT    wait cycles allowed for mem_ack before the access is aborted
//
// Ports:
//   clk           clock
//   rst           synchronous, active-high reset
//   mem_r_en      load pending (EX/MEM)
//   mem_w_en      store pending (EX/MEM)
//   alu_res       effective byte address (EX/MEM)
//   st_val        store data (EX/MEM)
//   bus           memory bus, master side (registered request outputs)
//   freeze        combinational stall for all upstream pipeline registers
//   ld_data       last completed load result, held until the next one
//   access_done   one-cycle pulse when an access finishes (any outcome)
//   bus_err       one-cycle pulse when an access is aborted on timeout
//   misalign_err  one-cycle pulse when a misaligned access is dropped
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
   parameter int ADDR_BASE = 1024,
   parameter int AW        = 8,
   parameter int TIMEOUT   = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mem_r_en,
   input  logic                mem_w_en,
   input  logic [31:0]         alu_res,
   input  logic [31:0]         st_val,
   mem_access_ctrl_if.master   bus,
   output logic                freeze,
   output logic [31:0]         ld_data,
   output logic                access_done,
   output logic                bus_err,
   output logic                misalign_err
);

   // Counter wide enough to hold TIMEOUT-1; the abort fires on that value.
   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic [31:0]   ld_data_q, ld_data_d;
   logic          access_done_q, access_done_d;
   logic          bus_err_q, bus_err_d;
   logic          misalign_err_q, misalign_err_d;

   logic          acc;
   logic          misaligned;
   logic [31:0]   off;

   assign acc        = mem_r_en | mem_w_en;
   assign misaligned = |alu_res[1:0];
   // Wrapping offset from the mapped base; addresses below the base alias
   // into the top of the word space after truncation.
   assign off        = alu_res - 32'(ADDR_BASE);

   // Next-state, next-register and stall logic. Every pulse output is
   // registered on the edge that enters DONE, so it is visible during the
   // DONE cycle together with access_done.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      mem_req_d      = mem_req_q;
      mem_we_d       = mem_we_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      ld_data_d      = ld_data_q;
      access_done_d  = 1'b0;
      bus_err_d      = 1'b0;
      misalign_err_d = 1'b0;
      freeze         = 1'b0;

      case (state_q)
         IDLE: begin
            if (acc) begin
               freeze = 1'b1;
               if (misaligned) begin
                  state_d        = DONE;
                  access_done_d  = 1'b1;
                  misalign_err_d = 1'b1;
               end else begin
                  // A store takes priority when both enables are set.
                  state_d     = BUSY;
                  cnt_d       = '0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = mem_w_en;
                  mem_addr_d  = AW'(off >> 2);
                  mem_wdata_d = st_val;
               end
            end
         end

         BUSY: begin
            freeze = 1'b1;
            // An ack on the last allowed wait cycle still completes normally.
            if (bus.mem_ack) begin
               state_d       = DONE;
               mem_req_d     = 1'b0;
               access_done_d = 1'b1;
               if (!mem_we_q) begin
                  ld_data_d = bus.mem_rdata;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d       = DONE;
               mem_req_d     = 1'b0;
               access_done_d = 1'b1;
               bus_err_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         DONE: begin
            // The pipeline advances at this edge; the next instruction is
            // looked at in the following IDLE cycle.
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // The stall must never hold the pipeline while it is being reset.
      if (rst) begin
         freeze = 1'b0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         mem_req_q      <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         ld_data_q      <= '0;
         access_done_q  <= 1'b0;
         bus_err_q      <= 1'b0;
         misalign_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         mem_req_q      <= mem_req_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         ld_data_q      <= ld_data_d;
         access_done_q  <= access_done_d;
         bus_err_q      <= bus_err_d;
         misalign_err_q <= misalign_err_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign ld_data       = ld_data_q;
   assign access_done   = access_done_q;
   assign bus_err       = bus_err_q;
   assign misalign_err  = misalign_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Self-checking bench for mem_access_ctrl. Acts as both the EX/MEM register
// (holding each instruction until its access_done cycle) and the data memory
// (acking a programmable number of cycles after mem_req rises).
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

   localparam int ADDR_BASE = 1024;
   localparam int AW        = 8;
   localparam int TIMEOUT   = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_r_en;
   logic        mem_w_en;
   logic [31:0] alu_res;
   logic [31:0] st_val;
   logic        freeze;
   logic [31:0] ld_data;
   logic        access_done;
   logic        bus_err;
   logic        misalign_err;

   int checks = 0;
   int errors = 0;
   int cyc_num = 0;

   mem_access_ctrl_if #(.AW(AW)) bus ();

   mem_access_ctrl #(
      .ADDR_BASE (ADDR_BASE),
      .AW        (AW),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_r_en     (mem_r_en),
      .mem_w_en     (mem_w_en),
      .alu_res      (alu_res),
      .st_val       (st_val),
      .bus          (bus.master),
      .freeze       (freeze),
      .ld_data      (ld_data),
      .access_done  (access_done),
      .bus_err      (bus_err),
      .misalign_err (misalign_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_num <= cyc_num + 1;

   // One instruction: inputs plus hand-derived expectations.
   typedef struct {
      logic        r;
      logic        w;
      logic [31:0] addr;
      logic [31:0] data;
      int          delay;
      logic [31:0] rdata;
      int          exp_freeze;
      int          exp_req;
      logic        exp_we;
      logic [7:0]  exp_addr;
      logic [31:0] exp_wdata;
      logic        exp_berr;
      logic        exp_mis;
      logic [31:0] exp_ld;
   } vec_t;

   // What the bench observed over one instruction.
   typedef struct {
      int          freeze_cnt;
      int          req_cnt;
      int          done_cnt;
      int          berr_cnt;
      int          mis_cnt;
      logic        we;
      logic [AW-1:0] addr;
      logic [31:0] wdata;
      int          req_cyc;
      int          done_cyc;
      bit          timed_out;
   } res_t;

   vec_t vecs [8];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_cycles(input int n);
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Presents one instruction and plays the memory until the access_done
   // cycle that belongs to it. Called just after a falling edge; returns
   // just after the falling edge of that access_done cycle.
   task automatic apply_stimulus(input logic r, input logic w, input logic [31:0] addr,
                                 input logic [31:0] data, input int delay,
                                 input logic [31:0] rdata, output res_t res);
      bit started = 0;
      int reqn = 0;
      res = '{default: 0};
      res.timed_out = 1;
      mem_r_en      = r;
      mem_w_en      = w;
      alu_res       = addr;
      st_val        = data;
      bus.mem_rdata = rdata;
      #1;
      for (int i = 0; i < 60; i++) begin
         if (freeze) started = 1;
         if (started) begin
            if (freeze) res.freeze_cnt++;
            if (bus.mem_req) begin
               if (reqn == 0) begin
                  res.we      = bus.mem_we;
                  res.addr    = bus.mem_addr;
                  res.wdata   = bus.mem_wdata;
                  res.req_cyc = cyc_num;
               end
               reqn++;
            end
            if (bus_err) res.berr_cnt++;
            if (misalign_err) res.mis_cnt++;
         end
         bus.mem_ack = started && bus.mem_req && (reqn == delay);
         if (started && access_done) begin
            res.done_cnt  = 1;
            res.done_cyc  = cyc_num;
            res.timed_out = 0;
            bus.mem_ack   = 1'b0;
            break;
         end
         @(negedge clk);
         #1;
      end
      res.req_cnt = reqn;
      if (res.timed_out) begin
         checks++;
         errors++;
         $display("[TB] FAIL access_timeout: got no access_done, expected one within 60 cycles");
      end
   endtask

   task automatic check_access(input string tag, input res_t res, input int ef, input int er,
                               input logic ewe, input logic [7:0] ea, input logic [31:0] ewd,
                               input logic eb, input logic em, input logic [31:0] eld);
      check_output({tag, " freeze_cycles"}, res.freeze_cnt, ef);
      check_output({tag, " req_cycles"}, res.req_cnt, er);
      check_output({tag, " access_done"}, res.done_cnt, 1);
      check_output({tag, " bus_err"}, res.berr_cnt, 32'(eb));
      check_output({tag, " misalign_err"}, res.mis_cnt, 32'(em));
      check_output({tag, " ld_data"}, ld_data, eld);
      if (er > 0) begin
         check_output({tag, " mem_we"}, 32'(res.we), 32'(ewe));
         check_output({tag, " mem_addr"}, 32'(res.addr), 32'(ea));
         check_output({tag, " mem_wdata"}, res.wdata, ewd);
      end
   endtask

   // Instruction-level reference: what one access should look like from the
   // outside, derived from alignment, ack delay and the timeout budget.
   task automatic model_access(input logic r, input logic w, input logic [31:0] addr,
                               input logic [31:0] data, input int delay,
                               input logic [31:0] rdata, inout logic [31:0] ld,
                               output int ef, output int er, output logic ewe,
                               output logic [7:0] ea, output logic [31:0] ewd,
                               output logic eb, output logic em);
      logic [31:0] off;
      bit acked;
      if (addr % 4 != 0) begin
         ef = 1; er = 0; ewe = 0; ea = 0; ewd = 0; eb = 0; em = 1;
      end else begin
         acked = (delay >= 1) && (delay <= TIMEOUT);
         er    = acked ? delay : TIMEOUT;
         ef    = er + 1;
         ewe   = w;
         off   = addr - 32'(ADDR_BASE);
         ea    = 8'((off / 4) % 256);
         ewd   = data;
         eb    = !acked;
         em    = 0;
         if (acked && !w && r) ld = rdata;
      end
   endtask

   initial begin
      res_t r1;
      res_t r2;
      logic [31:0] model_ld;

      rst           = 1'b1;
      mem_r_en      = 1'b1;
      mem_w_en      = 1'b0;
      alu_res       = 32'd1032;
      st_val        = 32'h0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;

      // Reset state, with a load pending to show freeze is gated by reset.
      repeat (3) @(negedge clk);
      #1;
      check_output("reset freeze", 32'(freeze), 0);
      check_output("reset mem_req", 32'(bus.mem_req), 0);
      check_output("reset mem_we", 32'(bus.mem_we), 0);
      check_output("reset mem_addr", 32'(bus.mem_addr), 0);
      check_output("reset mem_wdata", bus.mem_wdata, 0);
      check_output("reset ld_data", ld_data, 0);
      check_output("reset access_done", 32'(access_done), 0);
      check_output("reset bus_err", 32'(bus_err), 0);
      check_output("reset misalign_err", 32'(misalign_err), 0);
      mem_r_en = 1'b0;
      rst      = 1'b0;
      @(negedge clk);
      #1;

      // Directed vectors.
      vecs[0] = '{1'b1, 1'b0, 32'd1032, 32'h0,        3, 32'hDEADBEEF, 4, 3, 1'b0, 8'd2,   32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
      vecs[1] = '{1'b0, 1'b1, 32'd1024, 32'h12345678, 1, 32'h0,        2, 1, 1'b1, 8'd0,   32'h12345678, 1'b0, 1'b0, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 1'b0, 32'd1026, 32'h0,        1, 32'hCAFEF00D, 1, 0, 1'b0, 8'd0,   32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
      vecs[3] = '{1'b1, 1'b0, 32'd1040, 32'h0,        0, 32'h55555555, 5, 4, 1'b0, 8'd4,   32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
      vecs[4] = '{1'b1, 1'b1, 32'd1044, 32'hA5A5A5A5, 2, 32'hFFFFFFFF, 3, 2, 1'b1, 8'd5,   32'hA5A5A5A5, 1'b0, 1'b0, 32'hDEADBEEF};
      vecs[5] = '{1'b1, 1'b0, 32'd1020, 32'h0,        1, 32'h0BADF00D, 2, 1, 1'b0, 8'd255, 32'h0,        1'b0, 1'b0, 32'h0BADF00D};
      vecs[6] = '{1'b0, 1'b1, 32'd2048, 32'h600DCAFE, 4, 32'h0,        5, 4, 1'b1, 8'd0,   32'h600DCAFE, 1'b0, 1'b0, 32'h0BADF00D};
      vecs[7] = '{1'b0, 1'b1, 32'd1027, 32'h0,        1, 32'h0,        1, 0, 1'b0, 8'd0,   32'h0,        1'b0, 1'b1, 32'h0BADF00D};

      for (int i = 0; i < 8; i++) begin
         apply_stimulus(vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].data, vecs[i].delay, vecs[i].rdata, r1);
         check_access($sformatf("vec%0d", i), r1, vecs[i].exp_freeze, vecs[i].exp_req, vecs[i].exp_we,
                      vecs[i].exp_addr, vecs[i].exp_wdata, vecs[i].exp_berr, vecs[i].exp_mis, vecs[i].exp_ld);
         idle_cycles(1);
      end

      // Timeout followed by stray acks in DONE and then in IDLE.
      apply_stimulus(1'b1, 1'b0, 32'd1048, 32'h0, 0, 32'h77777777, r1);
      check_output("stray bus_err", r1.berr_cnt, 1);
      mem_r_en    = 1'b0;
      bus.mem_ack = 1'b1;
      @(negedge clk);
      #1;
      bus.mem_ack = 1'b1;
      check_output("stray done_clear", 32'(access_done), 0);
      check_output("stray bus_err_clear", 32'(bus_err), 0);
      @(negedge clk);
      #1;
      bus.mem_ack = 1'b0;
      check_output("stray mem_req", 32'(bus.mem_req), 0);
      check_output("stray freeze", 32'(freeze), 0);
      check_output("stray access_done", 32'(access_done), 0);
      check_output("stray ld_data", ld_data, 32'h0BADF00D);

      // Back-to-back loads with a single idle cycle between the requests.
      apply_stimulus(1'b1, 1'b0, 32'd1028, 32'h0, 2, 32'h11111111, r1);
      check_output("b2b first mem_addr", 32'(r1.addr), 1);
      check_output("b2b first ld_data", ld_data, 32'h11111111);
      check_output("b2b first req_cycles", r1.req_cnt, 2);
      apply_stimulus(1'b1, 1'b0, 32'd1036, 32'h0, 1, 32'h22222222, r2);
      check_output("b2b second mem_addr", 32'(r2.addr), 3);
      check_output("b2b second ld_data", ld_data, 32'h22222222);
      check_output("b2b second req_cycles", r2.req_cnt, 1);
      check_output("b2b request gap", r2.req_cyc - r1.done_cyc, 2);
      idle_cycles(1);

      // Reset in BUSY after two wait cycles, then a late ack.
      mem_r_en      = 1'b1;
      alu_res       = 32'd1032;
      bus.mem_rdata = 32'h99999999;
      begin
         bit seen = 0;
         for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = bus.mem_req;
         end
         check_output("rst_mid req_started", 32'(seen), 1);
      end
      repeat (2) begin
         @(negedge clk);
         #1;
      end
      rst = 1'b1;
      #1;
      check_output("rst_mid freeze_in_reset", 32'(freeze), 0);
      @(negedge clk);
      #1;
      rst         = 1'b0;
      mem_r_en    = 1'b0;
      bus.mem_ack = 1'b1;
      #1;
      check_output("rst_mid mem_req", 32'(bus.mem_req), 0);
      check_output("rst_mid freeze", 32'(freeze), 0);
      check_output("rst_mid access_done", 32'(access_done), 0);
      @(negedge clk);
      #1;
      bus.mem_ack = 1'b0;
      check_output("rst_mid late mem_req", 32'(bus.mem_req), 0);
      check_output("rst_mid late access_done", 32'(access_done), 0);
      check_output("rst_mid late bus_err", 32'(bus_err), 0);
      check_output("rst_mid ld_data", ld_data, 0);

      // Randomized instructions against the instruction-level model.
      model_ld = 32'h0;
      for (int n = 0; n < 40; n++) begin
         logic        rr, ww, eb, em, ewe;
         logic [31:0] addr, data, rdata, ewd;
         logic [7:0]  ea;
         int          delay, ef, er, kind;
         kind  = int'($urandom_range(0, 2));
         rr    = (kind != 1);
         ww    = (kind != 0);
         addr  = 32'(ADDR_BASE) + 32'($urandom_range(0, 600)) * 4 - 32'd400;
         if ($urandom_range(0, 4) == 0) addr = addr + 32'($urandom_range(1, 3));
         data  = $urandom;
         rdata = $urandom;
         delay = int'($urandom_range(0, 6));
         model_access(rr, ww, addr, data, delay, rdata, model_ld, ef, er, ewe, ea, ewd, eb, em);
         apply_stimulus(rr, ww, addr, data, delay, rdata, r1);
         check_access($sformatf("rand%0d", n), r1, ef, er, ewe, ea, ewd, eb, em, model_ld);
         idle_cycles(int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
